// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle shared between the four requesters and the
// round-robin arbiter. The arbiter takes the slave side; whoever drives
// the request vector takes the master side.
interface rr_arbiter4_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_valid;
  logic [CNT_W-1:0] busy_cnt;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  busy_cnt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output busy_cnt
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded tenure.
// The owner keeps the grant while it requests, for at most HOLD_MAX
// consecutive cycles. On release the rotation pointer moves past the owner
// and arbitration happens at the same edge, so a handoff never shows an
// idle cycle. All outputs are registered; req reaches them only via flops.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [3:0]       gnt_r;
  logic [1:0]       idx_r;
  logic             valid_r;
  logic [CNT_W-1:0] busy_r;

  logic             release_now;
  logic [1:0]       search_ptr;
  logic [1:0]       winner;
  logic             found;
  logic [1:0]       cand;

  // Release decision and round-robin search starting at the pointer that
  // will be in force after this edge (owner+1 when the owner lets go).
  always_comb begin
    release_now = (state == GRANT) &&
                  (!bus.req[idx_r] || (busy_r == HOLD_LAST));
    search_ptr  = release_now ? (idx_r + 2'd1) : ptr;
    winner      = search_ptr;
    found       = 1'b0;
    cand        = search_ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = search_ptr + 2'(i);
      if (bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Single state machine holding every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'b00;
      gnt_r   <= 4'b0000;
      idx_r   <= 2'b00;
      valid_r <= 1'b0;
      busy_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_r   <= 4'b0001 << winner;
            idx_r   <= winner;
            valid_r <= 1'b1;
            busy_r  <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!release_now) begin
            busy_r <= busy_r + 1'b1;
          end else begin
            ptr <= idx_r + 2'd1;
            if (found) begin
              gnt_r   <= 4'b0001 << winner;
              idx_r   <= winner;
              valid_r <= 1'b1;
              busy_r  <= '0;
            end else begin
              gnt_r   <= 4'b0000;
              valid_r <= 1'b0;
              busy_r  <= '0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = idx_r;
  assign bus.gnt_valid = valid_r;
  assign bus.busy_cnt  = busy_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4. Three arbiters with tenure limits of
// 8, 2 and 3 share one request vector and one reset. Each directed vector
// pushes the hand-computed post-edge result for one arbiter into a queue;
// a monitor pops and compares shortly after every rising edge.
module tb_rr_arbiter4;

  typedef struct {
    int         unit;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic [7:0] busy;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  exp_t exp_q[$];
  int   n_compared;
  int   n_mismatched;

  rr_arbiter4_if #(.CNT_W(8)) bus8 ();
  rr_arbiter4_if #(.CNT_W(8)) bus2 ();
  rr_arbiter4_if #(.CNT_W(8)) bus3 ();

  assign bus8.req = req;
  assign bus2.req = req;
  assign bus3.req = req;

  rr_arbiter4 #(.HOLD_MAX(8), .CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  rr_arbiter4 #(.HOLD_MAX(2), .CNT_W(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  rr_arbiter4 #(.HOLD_MAX(3), .CNT_W(8)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  // 10 time-unit clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one arbiter's present outputs with expected values.
  task automatic checkOutput(input int unit, input logic [3:0] g, input logic [1:0] i,
                             input logic v, input logic [7:0] b, input string name);
    logic [3:0] ag;
    logic [1:0] ai;
    logic       av;
    logic [7:0] ab;
    case (unit)
      2:       begin ag = bus2.gnt; ai = bus2.gnt_idx; av = bus2.gnt_valid; ab = bus2.busy_cnt; end
      3:       begin ag = bus3.gnt; ai = bus3.gnt_idx; av = bus3.gnt_valid; ab = bus3.busy_cnt; end
      default: begin ag = bus8.gnt; ai = bus8.gnt_idx; av = bus8.gnt_valid; ab = bus8.busy_cnt; end
    endcase
    n_compared++;
    if (ag !== g || ai !== i || av !== v || ab !== b) begin
      n_mismatched++;
      $display("[TB] FAIL %s (hold%0d): got gnt=%b idx=%0d valid=%b busy=%0d, want gnt=%b idx=%0d valid=%b busy=%0d",
               name, unit, ag, ai, av, ab, g, i, v, b);
    end
  endtask

  // Drive req for the next edge and queue the result expected after it.
  task automatic applyStimulus(input logic [3:0] r, input int unit, input logic [3:0] g,
                               input logic [1:0] i, input logic [7:0] b, input string name);
    exp_t e;
    @(negedge clk);
    req     = r;
    e.unit  = unit;
    e.gnt   = g;
    e.idx   = i;
    e.valid = |g;
    e.busy  = b;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic doReset(input string name);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(8, 4'b0000, 2'd0, 1'b0, 8'd0, name);
    checkOutput(2, 4'b0000, 2'd0, 1'b0, 8'd0, name);
    checkOutput(3, 4'b0000, 2'd0, 1'b0, 8'd0, name);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
  endtask

  // Monitor: just after each rising edge, check everything queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.unit, e.gnt, e.idx, e.valid, e.busy, e.name);
      end
    end
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    req          = 4'b0000;
    rst_n        = 1'b0;
    #1;
    checkOutput(8, 4'b0000, 2'd0, 1'b0, 8'd0, "reset_hold8");
    checkOutput(2, 4'b0000, 2'd0, 1'b0, 8'd0, "reset_hold2");
    checkOutput(3, 4'b0000, 2'd0, 1'b0, 8'd0, "reset_hold3");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: nothing granted while req stays zero.
    for (int k = 0; k < 5; k++)
      applyStimulus(4'b0000, 8, 4'b0000, 2'd0, 8'd0, "idle");

    // Single requester 2, three cycles then drop.
    applyStimulus(4'b0100, 8, 4'b0100, 2'd2, 8'd0, "single_first");
    applyStimulus(4'b0100, 8, 4'b0100, 2'd2, 8'd1, "single_hold1");
    applyStimulus(4'b0100, 8, 4'b0100, 2'd2, 8'd2, "single_hold2");
    applyStimulus(4'b0000, 8, 4'b0000, 2'd2, 8'd0, "single_drop");
    applyStimulus(4'b0000, 8, 4'b0000, 2'd2, 8'd0, "single_idle");

    // Early release: move ptr to 1, grant owner 1, drop it, wrap to 0.
    doReset("reset_early");
    applyStimulus(4'b0001, 8, 4'b0001, 2'd0, 8'd0, "early_own0");
    applyStimulus(4'b0000, 8, 4'b0000, 2'd0, 8'd0, "early_idle");
    applyStimulus(4'b0011, 8, 4'b0010, 2'd1, 8'd0, "early_own1");
    applyStimulus(4'b0001, 8, 4'b0001, 2'd0, 8'd0, "early_handoff");
    applyStimulus(4'b0001, 8, 4'b0001, 2'd0, 8'd1, "early_hold");

    // Full contention with a tenure of two cycles.
    doReset("reset_contend");
    applyStimulus(4'b1111, 2, 4'b0001, 2'd0, 8'd0, "contend_c0");
    applyStimulus(4'b1111, 2, 4'b0001, 2'd0, 8'd1, "contend_c1");
    applyStimulus(4'b1111, 2, 4'b0010, 2'd1, 8'd0, "contend_c2");
    applyStimulus(4'b1111, 2, 4'b0010, 2'd1, 8'd1, "contend_c3");
    applyStimulus(4'b1111, 2, 4'b0100, 2'd2, 8'd0, "contend_c4");
    applyStimulus(4'b1111, 2, 4'b0100, 2'd2, 8'd1, "contend_c5");
    applyStimulus(4'b1111, 2, 4'b1000, 2'd3, 8'd0, "contend_c6");
    applyStimulus(4'b1111, 2, 4'b1000, 2'd3, 8'd1, "contend_c7");
    applyStimulus(4'b1111, 2, 4'b0001, 2'd0, 8'd0, "contend_wrap");

    // Lone requester 3 with a tenure of three: re-granted without a gap.
    doReset("reset_lone");
    applyStimulus(4'b1000, 3, 4'b1000, 2'd3, 8'd0, "lone_c0");
    applyStimulus(4'b1000, 3, 4'b1000, 2'd3, 8'd1, "lone_c1");
    applyStimulus(4'b1000, 3, 4'b1000, 2'd3, 8'd2, "lone_c2");
    applyStimulus(4'b1000, 3, 4'b1000, 2'd3, 8'd0, "lone_regrant");
    applyStimulus(4'b1000, 3, 4'b1000, 2'd3, 8'd1, "lone_c4");
    applyStimulus(4'b1000, 3, 4'b1000, 2'd3, 8'd2, "lone_c5");
    applyStimulus(4'b1000, 3, 4'b1000, 2'd3, 8'd0, "lone_c6");

    // Reset in the middle of owner 1's tenure, then ptr restarts at 0.
    doReset("reset_pre_mid");
    applyStimulus(4'b0010, 8, 4'b0010, 2'd1, 8'd0, "mid_b0");
    applyStimulus(4'b0010, 8, 4'b0010, 2'd1, 8'd1, "mid_b1");
    applyStimulus(4'b0010, 8, 4'b0010, 2'd1, 8'd2, "mid_b2");
    applyStimulus(4'b0010, 8, 4'b0010, 2'd1, 8'd3, "mid_b3");
    applyStimulus(4'b0010, 8, 4'b0010, 2'd1, 8'd4, "mid_b4");
    doReset("reset_mid_grant");
    applyStimulus(4'b1111, 8, 4'b0001, 2'd0, 8'd0, "post_reset_first");
    applyStimulus(4'b1111, 8, 4'b0001, 2'd0, 8'd1, "post_reset_hold");

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter for a shared resource.
- Selects one requester and drives a registered one-hot grant, the same 2-to-4 decode produced by pdecoder2to4 from a 2-bit index.
- Also drives the 2-bit encoded index, so downstream muxes can select the owner's data.
- Grant is held while the owner keeps requesting, up to a programmable tenure limit. Then ownership rotates.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one requester may hold the grant. Legal range 1..255.
- CNT_W, 8, width of the tenure counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector. Bit i is requester i. Level-sensitive.
- gnt  output  4  one-hot grant. All zeros when idle.
- gnt_idx  output  2  encoded index of the current owner. Holds the last owner when idle.
- gnt_valid  output  1  high while any grant is active. Equals OR of gnt.
- busy_cnt  output  CNT_W  tenure cycles the current owner has completed. 0 when idle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, busy_cnt=0.
  - Internal state=IDLE, rotation pointer ptr=2'b00.
  - Outputs return to these values immediately, including mid-grant.
  - No grant is issued on the first edge after deassertion unless req is nonzero at that edge.
- States: IDLE, GRANT.
- Round-robin search:
  - Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4 (2-bit wrap 3->0).
  - The first set req bit in that order wins.
- IDLE:
  - At an edge with req==0: stay in IDLE, outputs unchanged.
  - At an edge with req!=0: winner w is registered.
  - Result: gnt=one-hot(w), gnt_idx=w, gnt_valid=1, busy_cnt=0, state=GRANT.
  - Latency is one cycle from req sampled to gnt visible.
- GRANT, owner o:
  - Continue condition: req[o]==1 and busy_cnt<HOLD_MAX-1. Then busy_cnt increments, grant unchanged.
  - Release condition: req[o]==0, or busy_cnt==HOLD_MAX-1. On release, ptr<=o+1 (wrap), then re-arbitrate at this same edge using the updated pointer value o+1.
  - Another requester wins: the new grant is registered at this edge with busy_cnt=0. No idle bubble; handoff is back-to-back.
  - No request remains after excluding a dropped owner: gnt=0, gnt_valid=0, busy_cnt=0, state=IDLE, gnt_idx keeps o.
  - Timed-out owner is the only requester: it is searched last and wins again. It is re-granted with busy_cnt=0, and gnt shows no glitch (stays one-hot(o)).
- Invariants:
  - gnt is always 0 or one-hot. gnt==(gnt_valid ? 1<<gnt_idx : 0).
  - busy_cnt never exceeds HOLD_MAX-1.
  - HOLD_MAX=1: every granted cycle is a release cycle. Owners rotate every cycle when all request.
- req bits changing between edges have no effect. Only edge-sampled values matter; there are no combinational paths from req to outputs.

Test Plan:
- Reset then idle: assert rst_n=0, then 1 with req=0 for 5 cycles -> gnt=0000, gnt_valid=0, gnt_idx=00, busy_cnt=0 every cycle.
- Single requester: req=0100 from cycle 0 -> gnt=0100, gnt_idx=10 one cycle later. Drop req after 3 cycles -> gnt=0000 on the next edge.
- Full contention with HOLD_MAX=2: req=1111 held -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001…, each owner exactly 2 cycles.
- Early release handoff: owner 1 is granted with req=0011. Drop req[1] at busy_cnt=0 -> next edge gnt=0001 directly (wrap from ptr=2 past 2,3 to 0), with no zero cycle.
- Lone timeout: HOLD_MAX=3, req=1000 held -> gnt stays 1000 continuously, busy_cnt cycles 0,1,2,0,1,2.
- Reset mid-grant: pulse rst_n low while gnt=0010 and busy_cnt=4 -> outputs clear asynchronously. After release with req=1111, first grant is 0001 (ptr reset to 0).
